// File: rtl/scope_plotter.sv
// scope_plotter: one-pixel-per-column oscilloscope sweep with per-column erase
// of the previous trace pixel. Optional rising-edge trigger: SCOPE_TRIGGER_EN.
module scope_plotter #(
    parameter int DECIM        = 150,
    parameter int X_MAX        = 319,
    parameter int Y_MID        = 119,
    parameter int TRIG_TIMEOUT = 640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] sample,
    input  logic        sample_tick,
    input  logic        pause,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic        vga_color,
    output logic        vga_plot,
`ifdef SCOPE_TRIGGER_EN
    output logic        trig_locked,
`endif
    output logic        busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERASE = 3'd1;
    localparam logic [2:0] S_DRAW  = 3'd2;
    localparam logic [2:0] S_ADV   = 3'd3;
    localparam logic [2:0] S_ARM   = 3'd4;
    localparam int DW = $clog2(DECIM);
    logic [2:0]        r_state, w_nxt;
    logic [DW-1:0]     r_dec;
    logic [8:0]        r_x;
    logic              r_first, r_pend;
    logic [7:0]        r_hold, r_ny;
    logic [7:0]        r_mem [0:X_MAX];
    logic signed [9:0] w_yr;
    logic [7:0]        w_y;
    logic              w_go, w_dec, w_wrap, w_unused;
    assign w_unused = ^sample[7:0] ^ (TRIG_TIMEOUT > 0);
    assign w_yr     = 10'(Y_MID) - {{2{r_hold[7]}}, r_hold};
    assign w_y      = w_yr < 0 ? 8'd0 : w_yr > 239 ? 8'd239 : w_yr[7:0];
    assign w_go     = r_pend && !pause && (r_state == S_IDLE || r_state == S_ARM);
    assign w_dec    = w_go && r_dec == DW'(DECIM - 1);
    assign w_wrap   = r_x == 9'(X_MAX);
`ifdef SCOPE_TRIGGER_EN
    localparam int TW = $clog2(TRIG_TIMEOUT);
    logic [TW-1:0] r_tcnt;
    logic          r_neg, w_cross, w_start;
    assign w_cross = r_neg && !r_hold[7];
    assign w_start = w_dec && (w_cross || r_tcnt == TW'(TRIG_TIMEOUT - 1));
    always_comb begin
        w_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_nxt = w_dec ? S_ERASE : S_IDLE;
            S_ERASE: w_nxt = S_DRAW;
            S_DRAW:  w_nxt = S_ADV;
            S_ADV:   w_nxt = w_wrap ? S_ARM : S_IDLE;
            S_ARM:   w_nxt = w_start ? S_ERASE : S_ARM;
            default: w_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt      <= '0;
            r_neg       <= 1'b0;
            trig_locked <= 1'b0;
        end else begin
            if (w_dec)
                r_neg <= r_hold[7];
            if (w_dec && r_state == S_ARM)
                r_tcnt <= w_start ? '0 : r_tcnt + 1'b1;
            if (w_start && r_state == S_ARM)
                trig_locked <= w_cross;
        end
    end
`else
    always_comb begin
        w_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_nxt = w_dec ? S_ERASE : S_IDLE;
            S_ERASE: w_nxt = S_DRAW;
            S_DRAW:  w_nxt = S_ADV;
            default: w_nxt = S_IDLE;
        endcase
    end
`endif
    // Output registers load on the transition into ERASE/DRAW so each pulse
    // is visible during the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_dec     <= '0;
            r_x       <= '0;
            r_first   <= 1'b1;
            r_pend    <= 1'b0;
            r_hold    <= '0;
            r_ny      <= '0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= 1'b0;
            vga_plot  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            busy     <= w_nxt != S_IDLE;
            vga_plot <= 1'b0;
            if (sample_tick && !pause) begin
                r_hold <= sample[15:8];
                r_pend <= 1'b1;
            end else if (w_go) begin
                r_pend <= 1'b0;
            end
            if (w_go)
                r_dec <= w_dec ? '0 : r_dec + 1'b1;
            if (w_dec)
                r_ny <= w_y;
            if (w_nxt == S_ERASE) begin
                vga_plot  <= !r_first;
                vga_x     <= r_x;
                vga_y     <= r_first ? vga_y : r_mem[r_x];
                vga_color <= 1'b0;
            end
            if (r_state == S_ERASE) begin
                vga_plot  <= 1'b1;
                vga_y     <= r_ny;
                vga_color <= 1'b1;
            end
            if (r_state == S_ADV) begin
                r_x <= w_wrap ? 9'd0 : r_x + 9'd1;
                if (w_wrap)
                    r_first <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (r_state == S_ERASE)
            r_mem[r_x] <= r_ny;
    end
endmodule

// File: tb/tb_scope_plotter.sv
// tb_scope_plotter: directed checks of sweep, erase, clamp, pause, overwrite and reset.
module tb_scope_plotter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sample = '0;
    logic        sample_tick = 1'b0;
    logic        pause = 1'b0;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic        vga_color, vga_plot, busy;
`ifdef SCOPE_TRIGGER_EN
    logic        trig_locked;
`endif
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, t_tick = 0, d_cyc = 0, e_cyc = 0;
    int          n_draw = 0, n_erase = 0;
    logic [8:0]  dx = '0, ex = '0;
    logic [7:0]  dy = '0, ey = '0;
    scope_plotter dut (
        .clk(clk), .reset_n(reset_n), .sample(sample), .sample_tick(sample_tick),
        .pause(pause), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .vga_plot(vga_plot),
`ifdef SCOPE_TRIGGER_EN
        .trig_locked(trig_locked),
`endif
        .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (vga_plot && vga_color) begin
            n_draw <= n_draw + 1;
            dx     <= vga_x;
            dy     <= vga_y;
            d_cyc  <= cyc;
        end else if (vga_plot) begin
            n_erase <= n_erase + 1;
            ex      <= vga_x;
            ey      <= vga_y;
            e_cyc   <= cyc;
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got cycle %0d want finish", cyc);
        $fatal(1);
    end
    // n back-to-back ticks of v, then idle long enough for a column to complete
    task automatic col(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sample      = v;
            sample_tick = 1'b1;
            t_tick      = cyc;
            @(negedge clk);
        end
        sample_tick = 1'b0;
        repeat (6) @(negedge clk);
    endtask
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({vga_x, vga_y, vga_color, vga_plot, busy} !== 20'd0)
            $display("FAIL reset_held got %h want 0", {vga_x, vga_y, vga_color, vga_plot, busy});
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({vga_x, vga_y, vga_color, vga_plot, busy} !== 20'd0)
            $display("FAIL reset_release got %h want 0", {vga_x, vga_y, vga_color, vga_plot, busy});
        else n_pass++;
    endtask
    task automatic test_first_column;
        col(16'h0000, 150);
        n_chk++;
        if (n_draw !== 1 || n_erase !== 0) $display("FAIL first_count got %0d/%0d want 1/0", n_draw, n_erase);
        else n_pass++;
        n_chk++;
        if ({dx, dy} !== {9'd0, 8'd119}) $display("FAIL first_xy got %0d,%0d want 0,119", dx, dy);
        else n_pass++;
        n_chk++;
        if (d_cyc - t_tick !== 3) $display("FAIL draw_latency got %0d want 3", d_cyc - t_tick);
        else n_pass++;
        col(16'h0000, 150);
        n_chk++;
        if (dx !== 9'd1 || n_erase !== 0) $display("FAIL second_col got x=%0d erases=%0d want 1/0", dx, n_erase);
        else n_pass++;
    endtask
    task automatic test_sweep_wrap;
        repeat (318) col(16'h0000, 150);
        col(16'h4000, 150);
        n_chk++;
        if (n_erase !== 1 || {ex, ey} !== {9'd0, 8'd119})
            $display("FAIL wrap_erase got n=%0d x=%0d y=%0d want 1,0,119", n_erase, ex, ey);
        else n_pass++;
        n_chk++;
        if ({dx, dy} !== {9'd0, 8'd55}) $display("FAIL wrap_draw got %0d,%0d want 0,55", dx, dy);
        else n_pass++;
        n_chk++;
        if (e_cyc - t_tick !== 2 || d_cyc - e_cyc !== 1)
            $display("FAIL erase_timing got %0d,%0d want 2,1", e_cyc - t_tick, d_cyc - e_cyc);
        else n_pass++;
    endtask
    task automatic test_clamp;
        logic [15:0] v [3] = '{16'h7FFF, 16'h8000, 16'hFF00};
        logic [7:0]  y [3] = '{8'd0, 8'd239, 8'd120};
        for (int i = 0; i < 3; i++) begin
            col(v[i], 150);
            n_chk++;
            if ({dx, dy, ey} !== {9'(i + 1), y[i], 8'd119})
                $display("FAIL clamp_%0d got x=%0d y=%0d ey=%0d want %0d,%0d,119", i, dx, dy, ey, i + 1, y[i]);
            else n_pass++;
        end
    endtask
    task automatic test_pause;
        int base;
        repeat (33) col(16'h0000, 150);
        col(16'h0000, 75);
        base  = n_draw + n_erase;
        pause = 1'b1;
        col(16'h4000, 1000);
        n_chk++;
        if (n_draw + n_erase !== base || busy !== 1'b0)
            $display("FAIL pause_frozen got plots=%0d busy=%b want %0d,0", n_draw + n_erase - base, busy, 0);
        else n_pass++;
        pause = 1'b0;
        col(16'h0000, 74);
        n_chk++;
        if (n_draw + n_erase !== base) $display("FAIL pause_dec got plots=%0d want 0", n_draw + n_erase - base);
        else n_pass++;
        col(16'h0000, 1);
        n_chk++;
        if (n_draw + n_erase !== base + 2 || dx !== 9'd37 || ex !== 9'd37)
            $display("FAIL pause_resume got plots=%0d x=%0d want 2,37", n_draw + n_erase - base, dx);
        else n_pass++;
    endtask
    task automatic test_back_to_back;
        int nd;
        col(16'h0000, 148);
        nd          = n_draw;
        sample      = 16'h7F00;
        sample_tick = 1'b1;
        @(negedge clk);
        sample      = 16'h2000;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++;
        if (n_draw !== nd + 1 || {dx, dy} !== {9'd38, 8'd87})
            $display("FAIL newest_wins got n=%0d x=%0d y=%0d want 1,38,87", n_draw - nd, dx, dy);
        else n_pass++;
    endtask
    task automatic test_reset_mid;
        int  nd, ne;
        logic found = 1'b0;
        for (int i = 0; i < 150; i++) begin
            sample      = 16'h0000;
            sample_tick = 1'b1;
            @(negedge clk);
        end
        sample_tick = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            found = vga_plot && !vga_color;
        end
        n_chk++;
        if (!found || vga_x !== 9'd39) $display("FAIL mid_erase got found=%b x=%0d want 1,39", found, vga_x);
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({vga_x, vga_y, vga_color, vga_plot, busy} !== 20'd0)
            $display("FAIL mid_reset_out got %h want 0", {vga_x, vga_y, vga_color, vga_plot, busy});
        else n_pass++;
        nd = n_draw;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (n_draw !== nd) $display("FAIL mid_no_draw got %0d want 0", n_draw - nd);
        else n_pass++;
        ne = n_erase;
        col(16'h4000, 150);
        n_chk++;
        if (n_erase !== ne || n_draw !== nd + 1 || {dx, dy} !== {9'd0, 8'd55})
            $display("FAIL after_reset got e=%0d d=%0d x=%0d y=%0d want 0,1,0,55", n_erase - ne, n_draw - nd, dx, dy);
        else n_pass++;
    endtask
    initial begin
        @(negedge clk);
        test_reset;
        test_first_column;
        test_sweep_wrap;
        test_clamp;
        test_pause;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
